// File: rtl/multi_channel_result_collector.sv
// multi_channel_result_collector
//   Gathers finished-batch results {pcoeffSum, pcoeffCount} from CHANNELS
//   independent pipelines. Each channel owns a private FIFO. The FIFOs are
//   merged round-robin into one registered valid/ready stream that carries
//   the source channel index.
// Ports
//   clk, rst            clock; synchronous active-low reset
//   resultValid         per-channel write strobe
//   pcoeffSum/Count     per-channel payload, channel c at slice c
//   slowDown            registered almost-full per channel
//   outValid/outReady   output handshake
//   outSum/outCount     merged payload
//   outChannel          source channel of the output payload
//   clearErrors         clears overflow and dropCount
//   overflow            sticky per-channel drop flag
//   dropCount           saturating total of dropped results

// Per-channel FIFO. Register storage with a combinational head, so a result
// written in cycle N can be popped by the arbiter at the end of cycle N+1.
module mccr_chan_fifo #(
  parameter int W                  = 55,
  parameter int DEPTH_LOG2         = 4,
  parameter int ALMOST_FULL_MARGIN = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         drop_o,
  output logic         slow_o
);
  localparam int D = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] ONE     = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] SLOW_TH = (DEPTH_LOG2+1)'(D - ALMOST_FULL_MARGIN);

  logic [W-1:0]          mem_q [D];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  full, wr_acc, slow_q;

  // Occupancy is D exactly when the extra MSB is set.
  assign full    = cnt_q[DEPTH_LOG2];
  assign empty_o = (cnt_q == '0);
  // A full FIFO still accepts if its head leaves in the same cycle.
  assign wr_acc  = wr_i && (!full || pop_i);
  assign drop_o  = wr_i && !wr_acc;
  assign rdata_o = mem_q[rptr_q];
  assign slow_o  = slow_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !pop_i)      cnt_d = cnt_q + ONE;
    else if (!wr_acc && pop_i) cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      slow_q <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      cnt_q  <= cnt_d;
      slow_q <= (cnt_d >= SLOW_TH);
    end
  end
endmodule

module multi_channel_result_collector #(
  parameter int CHANNELS              = 4,
  parameter int PCOEFF_COUNT_BITWIDTH = 10,
  parameter int DEPTH_LOG2            = 4,
  parameter int ALMOST_FULL_MARGIN    = 6,
  parameter int DROP_CNT_BITWIDTH     = 16,
  localparam int CW = PCOEFF_COUNT_BITWIDTH,
  localparam int SW = PCOEFF_COUNT_BITWIDTH + 35,
  localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          resultValid,
  input  logic [CHANNELS*SW-1:0]       pcoeffSum,
  input  logic [CHANNELS*CW-1:0]       pcoeffCount,
  output logic [CHANNELS-1:0]          slowDown,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [SW-1:0]                outSum,
  output logic [CW-1:0]                outCount,
  output logic [CB-1:0]                outChannel,
  input  logic                         clearErrors,
  output logic [CHANNELS-1:0]          overflow,
  output logic [DROP_CNT_BITWIDTH-1:0] dropCount
);
  localparam int W   = SW + CW;
  localparam int DW1 = DROP_CNT_BITWIDTH + 1;

  logic [CHANNELS-1:0] nonempty, empty, pop, drop, slow;
  logic [W-1:0]        rdata [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mccr_chan_fifo #(
      .W                  (W),
      .DEPTH_LOG2         (DEPTH_LOG2),
      .ALMOST_FULL_MARGIN (ALMOST_FULL_MARGIN)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .wr_i    (resultValid[c]),
      .wdata_i ({pcoeffSum[c*SW +: SW], pcoeffCount[c*CW +: CW]}),
      .pop_i   (pop[c]),
      .rdata_o (rdata[c]),
      .empty_o (empty[c]),
      .drop_o  (drop[c]),
      .slow_o  (slow[c])
    );
  end

  assign nonempty = ~empty;
  assign slowDown = slow;

  // Arbiter and output register
  logic          outValid_q;
  logic [SW-1:0] outSum_q;
  logic [CW-1:0] outCount_q;
  logic [CB-1:0] outChannel_q, ptr_q, gnt_idx;
  logic          gnt_any, load;
  logic [W-1:0]  head;
  int            idx;

  assign load = !outValid_q || outReady;

  // Search starts one past the last grant, so a just-served channel has
  // lowest priority next time.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    idx     = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(ptr_q) + i) % CHANNELS;
      if (!gnt_any && nonempty[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CB'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && gnt_any) pop[gnt_idx] = 1'b1;
  end

  assign head = rdata[gnt_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      outValid_q   <= 1'b0;
      outSum_q     <= '0;
      outCount_q   <= '0;
      outChannel_q <= '0;
      ptr_q        <= CB'(CHANNELS - 1);
    end else if (load) begin
      if (gnt_any) begin
        outValid_q   <= 1'b1;
        outSum_q     <= head[W-1:CW];
        outCount_q   <= head[CW-1:0];
        outChannel_q <= gnt_idx;
        ptr_q        <= gnt_idx;
      end else begin
        outValid_q   <= 1'b0;
      end
    end
  end

  assign outValid   = outValid_q;
  assign outSum     = outSum_q;
  assign outCount   = outCount_q;
  assign outChannel = outChannel_q;

  // Error tracking. Clear is applied before this cycle's drops, so a drop
  // coincident with clearErrors survives.
  logic [CHANNELS-1:0]          overflow_q, overflow_d;
  logic [DROP_CNT_BITWIDTH-1:0] dropCount_q, dropCount_d;
  logic [DW1-1:0]               drop_inc, drop_sum;

  always_comb begin
    drop_inc = '0;
    for (int c = 0; c < CHANNELS; c++) drop_inc = drop_inc + DW1'(drop[c]);
    drop_sum    = (clearErrors ? '0 : {1'b0, dropCount_q}) + drop_inc;
    dropCount_d = drop_sum[DW1-1] ? '1 : drop_sum[DROP_CNT_BITWIDTH-1:0];
    overflow_d  = (clearErrors ? '0 : overflow_q) | drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= '0;
      dropCount_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      dropCount_q <= dropCount_d;
    end
  end

  assign overflow  = overflow_q;
  assign dropCount = dropCount_q;
endmodule

// File: tb/tb_multi_channel_result_collector.sv
module tb_multi_channel_result_collector;
  localparam int CH = 4;
  localparam int CW = 10;
  localparam int SW = CW + 35;
  localparam int CB = 2;
  localparam int DCW = 16;

  logic              clk, rst;
  logic [CH-1:0]     resultValid;
  logic [CH*SW-1:0]  pcoeffSum;
  logic [CH*CW-1:0]  pcoeffCount;
  logic [CH-1:0]     slowDown;
  logic              outValid, outReady;
  logic [SW-1:0]     outSum;
  logic [CW-1:0]     outCount;
  logic [CB-1:0]     outChannel;
  logic              clearErrors;
  logic [CH-1:0]     overflow;
  logic [DCW-1:0]    dropCount;

  multi_channel_result_collector dut (
    .clk(clk), .rst(rst), .resultValid(resultValid), .pcoeffSum(pcoeffSum),
    .pcoeffCount(pcoeffCount), .slowDown(slowDown), .outValid(outValid),
    .outReady(outReady), .outSum(outSum), .outCount(outCount),
    .outChannel(outChannel), .clearErrors(clearErrors), .overflow(overflow),
    .dropCount(dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int   dch[$];
  longint dsum[$];
  int   dcnt[$];

  typedef struct {
    logic [3:0] rv;
    int         s;
    int         c;
    logic       rdy;
    logic       exp_ov;
    int         exp_ch;
    int         exp_sum;
    int         exp_cnt;
  } vec_t;
  vec_t vecs[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel k receives sum s+k and count c+k.
  task automatic drive(input logic [3:0] v, input int s, input int c,
                       input logic rdy, input logic clr);
    resultValid = v;
    for (int k = 0; k < CH; k++) begin
      pcoeffSum[k*SW +: SW]   = SW'(s + k);
      pcoeffCount[k*CW +: CW] = CW'(c + k);
    end
    outReady    = rdy;
    clearErrors = clr;
  endtask

  task automatic do_reset();
    drive(4'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic drain(input int budget, output int n);
    dch.delete(); dsum.delete(); dcnt.delete();
    n = 0;
    drive(4'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < budget; i++) begin
      if (outValid) begin
        dch.push_back(int'(outChannel));
        dsum.push_back(longint'(outSum));
        dcnt.push_back(int'(outCount));
        n++;
      end
      step();
    end
  endtask

  initial begin
    int n, errs;
    // rv, s, c, rdy, exp_ov, exp_ch, exp_sum, exp_cnt
    vecs[0]  = '{4'b1111, 200, 20, 1'b1, 1'b0, 0, 0, 0};
    vecs[1]  = '{4'b0000, 0,   0,  1'b1, 1'b1, 0, 200, 20};
    vecs[2]  = '{4'b0000, 0,   0,  1'b1, 1'b1, 1, 201, 21};
    vecs[3]  = '{4'b0000, 0,   0,  1'b1, 1'b1, 2, 202, 22};
    vecs[4]  = '{4'b0000, 0,   0,  1'b1, 1'b1, 3, 203, 23};
    vecs[5]  = '{4'b0000, 0,   0,  1'b1, 1'b0, 0, 0, 0};
    vecs[6]  = '{4'b0010, 122, 6,  1'b1, 1'b0, 0, 0, 0};
    vecs[7]  = '{4'b0000, 0,   0,  1'b1, 1'b1, 1, 123, 7};
    vecs[8]  = '{4'b0000, 0,   0,  1'b1, 1'b0, 0, 0, 0};
    vecs[9]  = '{4'b0011, 300, 30, 1'b1, 1'b0, 0, 0, 0};
    vecs[10] = '{4'b0011, 310, 40, 1'b1, 1'b1, 0, 300, 30};
    vecs[11] = '{4'b0000, 0,   0,  1'b1, 1'b1, 1, 301, 31};
    vecs[12] = '{4'b0000, 0,   0,  1'b1, 1'b1, 0, 310, 40};
    vecs[13] = '{4'b0000, 0,   0,  1'b1, 1'b1, 1, 311, 41};
    vecs[14] = '{4'b0000, 0,   0,  1'b1, 1'b0, 0, 0, 0};
    vecs[15] = '{4'b0100, 400, 50, 1'b0, 1'b0, 0, 0, 0};
    vecs[16] = '{4'b0000, 0,   0,  1'b0, 1'b1, 2, 402, 52};
    vecs[17] = '{4'b0100, 500, 60, 1'b0, 1'b1, 2, 402, 52};
    vecs[18] = '{4'b0000, 0,   0,  1'b0, 1'b1, 2, 402, 52};
    vecs[19] = '{4'b0000, 0,   0,  1'b1, 1'b1, 2, 502, 62};
    vecs[20] = '{4'b0000, 0,   0,  1'b1, 1'b0, 0, 0, 0};

    // Reset state
    drive(4'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    check("rst_outValid", outValid, 0);
    check("rst_outSum", outSum, 0);
    check("rst_outCount", outCount, 0);
    check("rst_outChannel", outChannel, 0);
    check("rst_slowDown", slowDown, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropCount", dropCount, 0);

    // Table: round-robin order, latency, backlog interleave, hold on !ready
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rv, vecs[i].s, vecs[i].c, vecs[i].rdy, 1'b0);
      step();
      check($sformatf("v%0d_outValid", i), outValid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) begin
        check($sformatf("v%0d_outChannel", i), outChannel, vecs[i].exp_ch);
        check($sformatf("v%0d_outSum", i), outSum, vecs[i].exp_sum);
        check($sformatf("v%0d_outCount", i), outCount, vecs[i].exp_cnt);
      end
      check($sformatf("v%0d_slowDown", i), slowDown, 0);
      check($sformatf("v%0d_overflow", i), overflow, 0);
    end

    // slowDown threshold on ch2 with output register occupied
    do_reset();
    drive(4'b0001, 600, 0, 1'b0, 1'b0); step();
    drive(4'b0000, 0, 0, 1'b0, 1'b0);   step();
    check("sd_preload_sum", outSum, 600);
    for (int i = 0; i < 10; i++) begin
      drive(4'b0100, 700 + i, i, 1'b0, 1'b0);
      step();
      if (i == 8) check("sd_after9", slowDown, 4'b0000);
      if (i == 9) check("sd_after10", slowDown, 4'b0100);
    end
    drain(20, n);
    check("sd_drain_n", n, 11);
    errs = 0;
    for (int i = 0; i < n && i < 11; i++) begin
      if (i == 0) begin
        if (dch[0] != 0 || dsum[0] != 600) errs++;
      end else if (dch[i] != 2 || dsum[i] != 701 + i || dcnt[i] != 1 + i) errs++;
    end
    check("sd_drain_order_errs", errs, 0);
    check("sd_after_drain", slowDown, 0);

    // Overflow on ch0: 17 writes, 16 kept
    do_reset();
    drive(4'b0010, 50, 5, 1'b0, 1'b0); step();
    drive(4'b0000, 0, 0, 1'b0, 1'b0);  step();
    for (int i = 0; i < 17; i++) begin
      drive(4'b0001, 1000 + i, i, 1'b0, 1'b0);
      step();
      if (i == 15) begin
        check("ov_full_overflow", overflow, 0);
        check("ov_full_drop", dropCount, 0);
        check("ov_full_slow", slowDown, 4'b0001);
      end
    end
    check("ov_overflow", overflow, 4'b0001);
    check("ov_dropCount", dropCount, 1);
    drain(30, n);
    check("ov_drain_n", n, 17);
    errs = 0;
    for (int i = 0; i < n && i < 17; i++) begin
      if (i == 0) begin
        if (dch[0] != 1 || dsum[0] != 51 || dcnt[0] != 6) errs++;
      end else if (dch[i] != 0 || dsum[i] != 999 + i || dcnt[i] != i - 1) errs++;
    end
    check("ov_drain_order_errs", errs, 0);
    check("ov_sticky", overflow, 4'b0001);
    drive(4'b0000, 0, 0, 1'b1, 1'b1); step();
    check("clr_overflow", overflow, 0);
    check("clr_dropCount", dropCount, 0);

    // Two channels dropping together, then clear racing a drop
    do_reset();
    drive(4'b0010, 0, 0, 1'b0, 1'b0); step();
    drive(4'b0000, 0, 0, 1'b0, 1'b0); step();
    for (int i = 0; i < 16; i++) begin
      drive(4'b1001, 2 * i, 0, 1'b0, 1'b0); step();
    end
    drive(4'b1001, 99, 0, 1'b0, 1'b0); step();
    check("dual_overflow", overflow, 4'b1001);
    check("dual_dropCount", dropCount, 2);
    drive(4'b1000, 99, 0, 1'b0, 1'b1); step();
    check("race_overflow", overflow, 4'b1000);
    check("race_dropCount", dropCount, 1);
    drain(50, n);
    check("dual_drain_n", n, 33);
    check("dual_first_ch", (n > 1) ? dch[1] : -1, 3);
    check("dual_second_ch", (n > 2) ? dch[2] : -1, 0);

    // dropCount saturation with a 4-wide popcount step
    do_reset();
    drive(4'b0001, 0, 0, 1'b0, 1'b0); step();
    drive(4'b0000, 0, 0, 1'b0, 1'b0); step();
    for (int i = 0; i < 16; i++) begin
      drive(4'b1111, i, 0, 1'b0, 1'b0); step();
    end
    for (int i = 0; i < 16383; i++) step();
    check("sat_before", dropCount, 65532);
    step();
    check("sat_hit", dropCount, 65535);
    step();
    check("sat_hold", dropCount, 65535);
    check("sat_overflow", overflow, 4'b1111);

    // Full FIFO written every cycle while draining: no drops
    do_reset();
    drive(4'b0001, 0, 0, 1'b0, 1'b0); step();
    drive(4'b0000, 0, 0, 1'b0, 1'b0); step();
    for (int i = 0; i < 16; i++) begin
      drive(4'b0001, 2000 + i, 0, 1'b0, 1'b0); step();
    end
    check("full_slow", slowDown, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      drive(4'b0001, 3000 + i, 0, 1'b1, 1'b0); step();
    end
    check("full_overflow", overflow, 0);
    check("full_dropCount", dropCount, 0);
    check("full_outSum", outSum, 2009);
    drain(30, n);
    check("full_drain_n", n, 17);
    check("full_drain_last", (n == 17) ? dsum[16] : -1, 3009);

    // Reset mid-operation discards everything
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'b0010, 4000 + i, 0, 1'b0, 1'b0); step();
    end
    check("mid_outValid_pre", outValid, 1);
    check("mid_outSum_pre", outSum, 4001);
    drive(4'b0000, 0, 0, 1'b0, 1'b0);
    rst = 1'b0; step(); rst = 1'b1;
    check("mid_outValid", outValid, 0);
    check("mid_slowDown", slowDown, 0);
    check("mid_outSum", outSum, 0);
    drain(20, n);
    check("mid_emitted", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
